// File: rtl/ct_mmu_sram_pkg.sv
// Shared definitions for the MMU single-port SRAM controller: geometry,
// sweep state encoding and the SRAM pin bundle.
package ct_mmu_sram_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 196;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } sweep_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] a;
        logic                  cen;
        logic                  gwen;
        logic [DATA_WIDTH-1:0] wen;
        logic [DATA_WIDTH-1:0] d;
    } sram_pins_t;

    // Pins for a cycle in which the macro is left deselected.
    function automatic sram_pins_t sram_idle_pins();
        sram_pins_t p;
        p.a    = '0;
        p.cen  = 1'b1;
        p.gwen = 1'b1;
        p.wen  = '1;
        p.d    = '0;
        return p;
    endfunction

endpackage

// File: rtl/ct_spsram_init_sweep.sv
// Zero-fill sweep sequencer: walks every entry once after reset or flush
// and pulses flush_done in the first idle cycle afterwards.
module ct_spsram_init_sweep
    import ct_mmu_sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_req,
    output logic                  sweep_active,
    output logic [ADDR_WIDTH-1:0] sweep_addr,
    output logic                  flush_done
);

    sweep_state_e          state_q, state_d;
    logic [ADDR_WIDTH:0]   init_cnt_q, init_cnt_d;
    logic                  flush_done_q, flush_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            init_cnt_q   <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            flush_done_q <= flush_done_d;
        end
    end

    // A flush arriving on the last sweep write restarts rather than completes,
    // so flush_done only ever fires once per uninterrupted pass.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        flush_done_d = 1'b0;
        case (state_q)
            INIT: begin
                if (flush_req) begin
                    init_cnt_d = '0;
                end else if (init_cnt_q == (ADDR_WIDTH+1)'(DEPTH - 1)) begin
                    state_d      = IDLE;
                    init_cnt_d   = '0;
                    flush_done_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (flush_req) begin
                    state_d    = INIT;
                    init_cnt_d = '0;
                end
            end
            default: begin
                state_d    = INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    assign sweep_active = (state_q == INIT);
    assign sweep_addr   = init_cnt_q[ADDR_WIDTH-1:0];
    assign flush_done   = flush_done_q;

endmodule

// File: rtl/ct_spsram_256x196_ctrl.sv
// Initiator-side controller for the 256x196 MMU SRAM: muxes the zero-fill
// sweep and the valid/ready request port onto the macro pins.
module ct_spsram_256x196_ctrl
    import ct_mmu_sram_pkg::*;
(
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  flush_req,
    output logic                  flush_busy,
    output logic                  flush_done,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    logic                  sweep_active;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  req_accept;
    logic                  rd_pend_q, rd_pend_d;
    sram_pins_t            pins;

    ct_spsram_init_sweep u_init_sweep (
        .clk          (forever_cpuclk),
        .rst_n        (cpurst_b),
        .flush_req    (flush_req),
        .sweep_active (sweep_active),
        .sweep_addr   (sweep_addr),
        .flush_done   (flush_done)
    );

    // flush_req blocks acceptance so no access slips in ahead of the sweep.
    assign req_rdy    = !sweep_active && !flush_req;
    assign req_accept = req_vld && req_rdy;
    assign flush_busy = sweep_active;

    always_comb begin
        pins      = sram_idle_pins();
        rd_pend_d = req_accept && !req_wr;
        if (sweep_active) begin
            pins.a    = sweep_addr;
            pins.cen  = 1'b0;
            pins.gwen = 1'b0;
            pins.wen  = '0;
            pins.d    = '0;
        end else if (req_accept) begin
            pins.a   = req_addr;
            pins.cen = 1'b0;
            if (req_wr) begin
                pins.gwen = 1'b0;
                pins.wen  = ~req_wmask;
                pins.d    = req_wdata;
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
        end
    end

    assign sram_a    = pins.a;
    assign sram_cen  = pins.cen;
    assign sram_gwen = pins.gwen;
    assign sram_wen  = pins.wen;
    assign sram_d    = pins.d;

    // The macro registers Q itself, so read data is forwarded untouched.
    assign rsp_vld  = rd_pend_q;
    assign rsp_data = sram_q;

endmodule

// File: tb/tb_ct_spsram_256x196_ctrl.sv
// Self-checking bench: behavioural SRAM macro plus an entry-level reference
// model of the controller, driven by directed and randomized traffic.
module tb_ct_spsram_256x196_ctrl;

    localparam int AW = 8;
    localparam int DW = 196;
    localparam int NENT = 256;

    logic          clk = 1'b0;
    logic          cpurst_b;
    logic          flush_req;
    logic          flush_busy;
    logic          flush_done;
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          rsp_vld;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [NENT];
    bit            m_busy;
    int            m_idx;
    bit            m_done;
    bit            m_rsp_vld;
    logic [DW-1:0] m_rsp_data;

    // Behavioural SRAM macro (active-low controls, registered Q on reads)
    logic [DW-1:0] sram_mem [NENT];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= sram_mem[sram_a];
        end
    end

    ct_spsram_256x196_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (cpurst_b),
        .flush_req      (flush_req),
        .flush_busy     (flush_busy),
        .flush_done     (flush_done),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_vld        (rsp_vld),
        .rsp_data       (rsp_data),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] randWord();
        logic [223:0] w;
        for (int i = 0; i < 7; i++) w[i*32 +: 32] = $urandom;
        return w[DW-1:0];
    endfunction

    // Entered at a negedge; drives one cycle, checks it, advances the model,
    // and returns at the following negedge.
    task automatic applyStimulus(input bit vld, input bit wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] wmask,
                                 input bit flush);
        bit            exp_rdy;
        bit            acc;
        logic          e_cen, e_gwen;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_wen, e_d;
        req_vld   = vld;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        flush_req = flush;
        #1;
        exp_rdy = !m_busy && !flush;
        acc     = vld && exp_rdy;
        checkOutput("req_rdy",    DW'(req_rdy),    DW'(exp_rdy));
        checkOutput("flush_busy", DW'(flush_busy), DW'(m_busy));
        checkOutput("flush_done", DW'(flush_done), DW'(m_done));
        checkOutput("rsp_vld",    DW'(rsp_vld),    DW'(m_rsp_vld));
        if (m_rsp_vld) checkOutput("rsp_data", rsp_data, m_rsp_data);

        if (m_busy) begin
            e_cen = 1'b0; e_gwen = 1'b0; e_a = AW'(m_idx); e_wen = '0; e_d = '0;
        end else if (acc) begin
            e_cen  = 1'b0;
            e_a    = addr;
            e_gwen = wr ? 1'b0 : 1'b1;
            e_wen  = wr ? ~wmask : '1;
            e_d    = wr ? wdata : '0;
        end else begin
            e_cen = 1'b1; e_gwen = 1'b1; e_a = '0; e_wen = '1; e_d = '0;
        end
        checkOutput("sram_cen",  DW'(sram_cen),  DW'(e_cen));
        checkOutput("sram_gwen", DW'(sram_gwen), DW'(e_gwen));
        checkOutput("sram_a",    DW'(sram_a),    DW'(e_a));
        checkOutput("sram_wen",  sram_wen,       e_wen);
        checkOutput("sram_d",    sram_d,         e_d);

        m_rsp_vld  = acc && !wr;
        m_rsp_data = ref_mem[addr];
        if (acc && wr) ref_mem[addr] = (ref_mem[addr] & ~wmask) | (wdata & wmask);
        m_done = 1'b0;
        if (m_busy) begin
            ref_mem[m_idx] = '0;
            if (flush) m_idx = 0;
            else if (m_idx == NENT - 1) begin
                m_busy = 1'b0;
                m_idx  = 0;
                m_done = 1'b1;
            end else m_idx++;
        end else if (flush) begin
            m_busy = 1'b1;
            m_idx  = 0;
        end
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic readEntry(input logic [AW-1:0] addr);
        applyStimulus(1'b1, 1'b0, addr, randWord(), randWord(), 1'b0);
    endtask

    task automatic writeEntry(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [DW-1:0] mask);
        applyStimulus(1'b1, 1'b1, addr, data, mask, 1'b0);
    endtask

    // Runs the model-predicted remainder of a sweep, never more than one pass.
    task automatic runSweep();
        for (int i = 0; i < NENT + 2 && m_busy; i++) idleCycle();
    endtask

    // Entered and left at a negedge; during reset the sweep pins still select
    // entry 0, so the macro writes zero there on every reset clock.
    task automatic resetPulse(input int cycles);
        cpurst_b  = 1'b0;
        req_vld   = 1'b0;
        flush_req = 1'b0;
        #1;
        checkOutput("rst_rsp_vld",    DW'(rsp_vld),    DW'(1'b0));
        checkOutput("rst_req_rdy",    DW'(req_rdy),    DW'(1'b0));
        checkOutput("rst_flush_busy", DW'(flush_busy), DW'(1'b1));
        checkOutput("rst_flush_done", DW'(flush_done), DW'(1'b0));
        repeat (cycles) @(negedge clk);
        cpurst_b   = 1'b1;
        ref_mem[0] = '0;
        m_busy     = 1'b1;
        m_idx      = 0;
        m_done     = 1'b0;
        m_rsp_vld  = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] pat_a;
        logic [DW-1:0] wmask;
        cpurst_b  = 1'b0;
        flush_req = 1'b0;
        req_vld   = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        for (int i = 0; i < NENT; i++) begin
            sram_mem[i] = randWord();
            ref_mem[i]  = sram_mem[i];
        end
        m_busy = 1'b1; m_idx = 0; m_done = 1'b0; m_rsp_vld = 1'b0; m_rsp_data = '0;

        @(negedge clk);
        resetPulse(3);
        runSweep();
        readEntry(8'h00);
        readEntry(8'h7F);
        readEntry(8'hFF);
        idleCycle();

        for (int i = 0; i < DW / 4; i++) pat_a[i*4 +: 4] = 4'h5;
        writeEntry(8'h12, pat_a, '1);
        readEntry(8'h12);
        idleCycle();

        writeEntry(8'h20, '1, DW'(4'hF));
        readEntry(8'h20);
        idleCycle();

        for (int i = 1; i <= 3; i++) writeEntry(AW'(i), randWord(), '1);
        for (int i = 1; i <= 3; i++) readEntry(AW'(i));
        idleCycle();

        applyStimulus(1'b1, 1'b0, 8'h12, '0, '0, 1'b1);
        repeat (99) idleCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        runSweep();
        readEntry(8'h12);
        readEntry(8'h01);
        idleCycle();

        writeEntry(8'h05, randWord(), '1);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        repeat (49) idleCycle();
        resetPulse(2);
        runSweep();
        readEntry(8'h05);
        resetPulse(2);
        runSweep();
        idleCycle();

        for (int n = 0; n < 1500; n++) begin
            bit            vld, wr, flush;
            logic [AW-1:0] addr;
            vld   = ($urandom_range(0, 3) != 0);
            wr    = $urandom_range(0, 1) == 1;
            addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wmask = ($urandom_range(0, 1) == 1) ? '1 : randWord();
            flush = ($urandom_range(0, 299) == 0);
            applyStimulus(vld, wr, addr, randWord(), wmask, flush);
        end
        idleCycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ct_spsram_256x196_ctrl.md
Name: ct_spsram_256x196_ctrl

Overview:
Initiator-side controller for the 256x196 single-port MMU SRAM (active-low CEN/GWEN/per-bit WEN, one-cycle registered read). It arbitrates a valid/ready request port onto the SRAM pins and returns read data with a response strobe. It also runs a zero-fill sweep after reset or on a flush request. It sits between the jTLB/MMU access logic and the SRAM macro wrapper.

Parameters:
ADDR_WIDTH, 8, SRAM address width
DATA_WIDTH, 196, SRAM data width and write-enable width
DEPTH, 256, entries swept by init (2**ADDR_WIDTH)

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  async active-low reset
flush_req  in  1  pulse; start zero-fill sweep
flush_busy  out  1  sweep in progress
flush_done  out  1  one-cycle pulse when sweep finishes
req_vld  in  1  access request
req_rdy  out  1  controller accepts request this cycle
req_wr  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  entry index
req_wdata  in  DATA_WIDTH  write data
req_wmask  in  DATA_WIDTH  active-high bit write mask
rsp_vld  out  1  read data valid pulse
rsp_data  out  DATA_WIDTH  read data, valid only with rsp_vld
sram_a  out  ADDR_WIDTH  SRAM address
sram_cen  out  1  SRAM chip enable, active low
sram_gwen  out  1  SRAM global write enable, active low
sram_wen  out  DATA_WIDTH  SRAM bit write enable, active low
sram_d  out  DATA_WIDTH  SRAM write data
sram_q  in  DATA_WIDTH  SRAM read data

Behaviour:
- Clocking: single clock forever_cpuclk. Reset cpurst_b is asynchronous and active-low.
- States: INIT, IDLE. Reset enters INIT with init_cnt=0.
- INIT:
  - Each cycle drives sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=init_cnt, then increments init_cnt.
  - When init_cnt==DEPTH-1 is written, go to IDLE and pulse flush_done in the following cycle, the first IDLE cycle.
  - Sweep length is exactly DEPTH cycles.
  - req_rdy=0 and flush_busy=1 throughout INIT.
- IDLE: req_rdy=1 and flush_busy=0. A request is accepted when req_vld && req_rdy. SRAM pins are driven combinationally in the same cycle:
  - All accesses: sram_cen=0, sram_a=req_addr.
  - Write: sram_gwen=0, sram_wen=~req_wmask, sram_d=req_wdata.
  - Read: sram_gwen=1, sram_wen=all 1.
- Idle pins: with no accepted request, sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- Read latency 1:
  - rd_pend flop is set on an accepted read.
  - rsp_vld=rd_pend in the next cycle; rsp_data=sram_q passthrough and is not registered.
  - Back-to-back reads give a response every cycle.
  - Writes produce no response.
- Flush:
  - flush_req in IDLE moves to INIT next cycle with init_cnt=0. A request presented in that same cycle is not accepted, because req_rdy is gated by flush_req.
  - flush_req during INIT restarts init_cnt at 0; flush_done pulses only once, at the final completion.
  - A pending read response (rd_pend) still fires rsp_vld in the cycle after flush_req, because the sweep write does not disturb Q for that cycle's sample.
- Write then read to the same address in consecutive cycles returns the new data (SRAM write-through is not used).
- Reset values: state=INIT, init_cnt=0, rd_pend=0, flush_done=0. In reset: rsp_vld=0, req_rdy=0, flush_busy=1.
- Reset asserted mid-sweep or mid-read drops rd_pend and restarts the sweep from 0 after release.
- Boundaries:
  - init_cnt is ADDR_WIDTH+1 bits wide so it does not wrap before completion detection.
  - req_addr uses the full range 0..255 with no aliasing.

Decomposition:
- Shared package ct_mmu_sram_pkg holds the state encoding (INIT=1'b0, IDLE=1'b1), the ADDR_WIDTH/DATA_WIDTH/DEPTH constants, and an SRAM pin-bundle typedef {a, cen, gwen, wen, d}.
- One sub-module, ct_spsram_init_sweep, is natural: it holds the counter, the done pulse and the restart-on-flush logic.
- The top module muxes between the sweep and request paths and instantiates ct_spsram_256x196 only in the bench.

Test Plan:
1. Reset release -> exactly 256 cycles with sram_cen=0/gwen=0/d=0 at addresses 0..255, then flush_done one pulse and req_rdy=1; reads of 0x00, 0x7F, 0xFF return 0.
2. Write addr 0x12, data pattern A (196'h5...5), mask all 1; next-cycle read 0x12 -> rsp_vld in the cycle after the read accept with rsp_data=A.
3. Partial write: mask=196'hF (low 4 bits), data all 1 onto a zeroed entry; read -> rsp_data=196'hF.
4. Reads to 0x01, 0x02, 0x03 on consecutive cycles -> three consecutive rsp_vld pulses, data in order, one cycle after each accept.
5. flush_req while IDLE with req_vld=1 -> request not accepted, 256-cycle sweep; flush_req again at sweep cycle 100 -> sweep restarts, single flush_done after 256 more cycles; prior data reads back 0.
6. cpurst_b asserted at sweep cycle 50 and during a pending read -> rsp_vld stays 0, sweep restarts from addr 0 after release.
